hazard_fwd_ctrl: RTL and testbench
==================================

# hazard_fwd_ctrl

Pipeline hazard and forwarding controller for the 16-bit five-stage core (IF, ID, EX, MEM, WB). It keeps a tag shadow of the destination registers in flight in EX, MEM and WB. From those tags it generates the registered 2-bit select codes for the two EX-stage 4:1 operand multiplexers. It also drives the stall, bubble, flush and freeze controls for the PC and the pipeline registers.

## Interface
- REG_AW, 2: register-index width (4 architectural registers).
- CNT_W, 16: width of the stall performance counter.

- clk  in  1  core clock, all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt  in  REG_AW  source register indices of the ID instruction.
- id_use_rs, id_use_rt  in  1  the corresponding source is actually read.
- id_rd  in  REG_AW  destination index of the ID instruction.
- id_reg_write  in  1  the ID instruction writes id_rd.
- id_mem_read  in  1  the ID instruction is a load.
- ex_branch_taken  in  1  EX resolved a taken branch or jump this cycle.
- mem_busy  in  1  data memory is not ready; the whole pipeline must hold.
- pc_write  out  1  PC update enable.
- ifid_write  out  1  IF/ID register enable.
- ifid_flush  out  1  clear IF/ID to a bubble.
- idex_bubble  out  1  load a NOP into ID/EX instead of the ID instruction.
- pipe_freeze  out  1  hold ID/EX, EX/MEM and MEM/WB.
- fwd_a_sel, fwd_b_sel  out  2  operand mux selects, registered, valid for the instruction currently in EX.
- stall_cycles  out  CNT_W  saturating count of cycles with a hazard stall or memory freeze.

## Operation
- Tag stages: ex_t, mem_t, wb_t. Each tag is {valid, rd, reg_write, mem_read}.
- Advance when pipe_freeze=0:
  - wb_t ← mem_t
  - mem_t ← ex_t
  - ex_t ← ID tag, or an invalid tag when idex_bubble=1
- When pipe_freeze=1, all tags and both selects hold.
- Match definition: a source "matches" stage X when the source is used, X is valid, X has reg_write set, and X.rd equals the source index.
- Select codes, computed from the ID instruction and loaded when ID advances into EX:
  - 0: register file.
  - 1: EX/MEM ALU result, for a match on ex_t.
  - 2: MEM/WB result, for a match on mem_t.
  - 3: WB retire latch, for a match on wb_t.
  - Priority is the youngest match: ex_t > mem_t > wb_t.
  - A bubble loads 0 into both selects.
- Load-use hazard: a source matches ex_t and ex_t.mem_read=1. Response:
  - pc_write=0, ifid_write=0, idex_bubble=1 for exactly one cycle.
  - In the next cycle the load sits in mem_t and the select is 2.
- Control priority, highest first:
  1. mem_busy: pipe_freeze=1, pc_write=0, ifid_write=0, idex_bubble=0, ifid_flush=0. The controller holds state.
  2. ex_branch_taken: ifid_flush=1, idex_bubble=1, pc_write=1. The ID instruction is dropped and no hazard stall is raised.
  3. Hazard stall, as above.
  4. Normal: pc_write=1, ifid_write=1, all other controls 0.
- id_valid=0 never raises a hazard and loads an invalid tag.
- stall_cycles increments on every cycle with (hazard stall | mem_busy) and saturates at all-ones.

## Timing
- Control outputs are combinational from the inputs and current tags, settling within the same cycle.
- fwd_a_sel and fwd_b_sel are registered: they are computed in the ID cycle and presented in the EX cycle.
- Reset values:
  - Tags: all invalid.
  - fwd_a_sel=0, fwd_b_sel=0, stall_cycles=0.
  - Controls reflect empty tags: pc_write=1, ifid_write=1, others 0 while reset_n=0.
- Reset mid-stall clears all tags immediately; the next cycle after release is a normal cycle.
- Simultaneous load-use and ex_branch_taken: the flush wins and no stall cycle is counted.
- Simultaneous mem_busy and either of the above: the freeze wins, and the branch or hazard is re-evaluated when mem_busy drops.
- Two matching stages: the youngest wins (the ex_t match over mem_t).

## Configuration
- HAZARD_FWD_EN defined: forwarding as above. Only load-use stalls, 1 cycle.
- HAZARD_FWD_EN undefined:
  - Selects are tied to 0.
  - Any match on ex_t, mem_t or wb_t raises the hazard stall, held until no match remains.
  - A dependent instruction stalls 3 cycles after its producer enters EX.

## Test plan
- Back-to-back `add r1` then `add r2,r1,r1` → fwd_a_sel=fwd_b_sel=1 in the consumer's EX cycle, no stall, stall_cycles=0.
- Load r2 followed immediately by a use of r2 in rs → one cycle with pc_write=0, ifid_write=0, idex_bubble=1; then fwd_a_sel=2; stall_cycles=1.
- Producer r3, two independent instructions, then a consumer of r3 in rt → fwd_b_sel=3. The same sequence with r3 also rewritten by the middle instruction → fwd_b_sel=1.
- Load-use asserted together with ex_branch_taken=1 → ifid_flush=1, idex_bubble=1, pc_write=1, stall_cycles unchanged.
- mem_busy high for 4 cycles during a load-use → pipe_freeze=1 for 4 cycles, selects and tags hold, stall_cycles +4; then the single load-use stall follows (+1).
- Build without HAZARD_FWD_EN, run the first scenario → 3 stall cycles, selects 0. Assert reset_n=0 mid-stall → tags clear and pc_write=1.

Source files
------------

// File: rtl/hazard_fwd_ctrl.sv
// Hazard detection and operand-forwarding control for the five-stage core.
// Define HAZARD_FWD_EN to enable forwarding; otherwise every RAW dependence stalls.
module hazard_fwd_ctrl #(
    parameter int REG_AW = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              ex_branch_taken,
    input  logic              mem_busy,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              pipe_freeze,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic [CNT_W-1:0]  stall_cycles
);

    // Tag layout: {valid, rd, reg_write[, mem_read]}; only EX needs mem_read.
    localparam int EX_W  = REG_AW + 3;
    localparam int OLD_W = REG_AW + 2;

    logic [EX_W-1:0]   ex_tag_r;
    logic [OLD_W-1:0]  mem_tag_r;
    logic [OLD_W-1:0]  wb_tag_r;
    logic [1:0]        fwd_a_r;
    logic [1:0]        fwd_b_r;
    logic [CNT_W-1:0]  stall_cnt_r;

    logic              a_ex_s, a_mem_s, a_wb_s;
    logic              b_ex_s, b_mem_s, b_wb_s;
    logic              hazard_s;
    logic              stall_evt_s;
    logic [1:0]        fwd_a_nxt_s;
    logic [1:0]        fwd_b_nxt_s;
    logic              pc_write_s, ifid_write_s, ifid_flush_s, idex_bubble_s, pipe_freeze_s;

    function automatic logic src_match(input logic used, input logic [REG_AW-1:0] src,
                                       input logic v, input logic [REG_AW-1:0] rd, input logic rw);
        return used & v & rw & (rd == src);
    endfunction

    // Youngest producer wins.
    function automatic logic [1:0] fwd_code(input logic m_ex, input logic m_mem, input logic m_wb);
        logic [1:0] code;
        if (m_ex) begin
            code = 2'd1;
        end else if (m_mem) begin
            code = 2'd2;
        end else if (m_wb) begin
            code = 2'd3;
        end else begin
            code = 2'd0;
        end
        return code;
    endfunction

    // Source matches against the in-flight destination tags.
    always_comb begin
        a_ex_s  = id_valid & src_match(id_use_rs, id_rs, ex_tag_r[EX_W-1], ex_tag_r[EX_W-2:2], ex_tag_r[1]);
        a_mem_s = id_valid & src_match(id_use_rs, id_rs, mem_tag_r[OLD_W-1], mem_tag_r[OLD_W-2:1], mem_tag_r[0]);
        a_wb_s  = id_valid & src_match(id_use_rs, id_rs, wb_tag_r[OLD_W-1], wb_tag_r[OLD_W-2:1], wb_tag_r[0]);
        b_ex_s  = id_valid & src_match(id_use_rt, id_rt, ex_tag_r[EX_W-1], ex_tag_r[EX_W-2:2], ex_tag_r[1]);
        b_mem_s = id_valid & src_match(id_use_rt, id_rt, mem_tag_r[OLD_W-1], mem_tag_r[OLD_W-2:1], mem_tag_r[0]);
        b_wb_s  = id_valid & src_match(id_use_rt, id_rt, wb_tag_r[OLD_W-1], wb_tag_r[OLD_W-2:1], wb_tag_r[0]);
    end

`ifdef HAZARD_FWD_EN
    assign hazard_s    = (a_ex_s | b_ex_s) & ex_tag_r[0];
    assign fwd_a_nxt_s = fwd_code(a_ex_s, a_mem_s, a_wb_s);
    assign fwd_b_nxt_s = fwd_code(b_ex_s, b_mem_s, b_wb_s);
`else
    logic unused_ex_mr_s;
    assign unused_ex_mr_s = ex_tag_r[0];
    assign hazard_s    = a_ex_s | a_mem_s | a_wb_s | b_ex_s | b_mem_s | b_wb_s;
    assign fwd_a_nxt_s = 2'd0;
    assign fwd_b_nxt_s = 2'd0;
`endif

    // Pipeline control priority: freeze, branch flush, hazard stall, normal.
    always_comb begin
        pc_write_s    = 1'b1;
        ifid_write_s  = 1'b1;
        ifid_flush_s  = 1'b0;
        idex_bubble_s = 1'b0;
        pipe_freeze_s = 1'b0;
        if (!reset_n) begin
            pc_write_s = 1'b1;
        end else if (mem_busy) begin
            pipe_freeze_s = 1'b1;
            pc_write_s    = 1'b0;
            ifid_write_s  = 1'b0;
        end else if (ex_branch_taken) begin
            ifid_flush_s  = 1'b1;
            idex_bubble_s = 1'b1;
        end else if (hazard_s) begin
            pc_write_s    = 1'b0;
            ifid_write_s  = 1'b0;
            idex_bubble_s = 1'b1;
        end else begin
            pc_write_s = 1'b1;
        end
    end

    assign stall_evt_s = mem_busy | (hazard_s & ~ex_branch_taken);

    // Tag shadow and forwarding selects advance together with ID/EX.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_tag_r  <= {EX_W{1'b0}};
            mem_tag_r <= {OLD_W{1'b0}};
            wb_tag_r  <= {OLD_W{1'b0}};
            fwd_a_r   <= 2'd0;
            fwd_b_r   <= 2'd0;
        end else if (!pipe_freeze_s) begin
            wb_tag_r  <= mem_tag_r;
            mem_tag_r <= ex_tag_r[EX_W-1:1];
            if (idex_bubble_s) begin
                ex_tag_r <= {EX_W{1'b0}};
                fwd_a_r  <= 2'd0;
                fwd_b_r  <= 2'd0;
            end else begin
                ex_tag_r <= {id_valid, id_rd, id_reg_write, id_mem_read};
                fwd_a_r  <= fwd_a_nxt_s;
                fwd_b_r  <= fwd_b_nxt_s;
            end
        end
    end

    // Saturating count of stall and freeze cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (stall_evt_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign pc_write     = pc_write_s;
    assign ifid_write   = ifid_write_s;
    assign ifid_flush   = ifid_flush_s;
    assign idex_bubble  = idex_bubble_s;
    assign pipe_freeze  = pipe_freeze_s;
    assign fwd_a_sel    = fwd_a_r;
    assign fwd_b_sel    = fwd_b_r;
    assign stall_cycles = stall_cnt_r;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Randomized self-checking bench for hazard_fwd_ctrl against an in-flight instruction model.
module tb_hazard_fwd_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        id_valid;
    logic [1:0]  id_rs, id_rt, id_rd;
    logic        id_use_rs, id_use_rt, id_reg_write, id_mem_read;
    logic        ex_branch_taken, mem_busy;
    logic        pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic [15:0] stall_cycles;

    hazard_fwd_ctrl #(.REG_AW(2), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .pipe_freeze(pipe_freeze),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit v;
        int rd;
        bit rw;
        bit mr;
    } instr_t;

    // Index 0 = EX (youngest), 1 = MEM, 2 = WB.
    instr_t flight[3];
    int     exp_a, exp_b, exp_cnt;
    int     total = 0;
    int     bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Returns 0 for register file, else 1 + age of youngest in-flight writer of src.
    function automatic int source_of(input bit used, input int src);
        if (!used) return 0;
        for (int s = 0; s < 3; s++)
            if (flight[s].v && flight[s].rw && flight[s].rd == src) return s + 1;
        return 0;
    endfunction

    task automatic clear_model();
        for (int s = 0; s < 3; s++) flight[s] = '{0, 0, 0, 0};
        exp_a   = 0;
        exp_b   = 0;
        exp_cnt = 0;
    endtask

    task automatic randomize_inputs();
        id_valid        = ($urandom_range(0, 99) < 85);
        id_rs           = 2'($urandom_range(0, 3));
        id_rt           = 2'($urandom_range(0, 3));
        id_rd           = 2'($urandom_range(0, 3));
        id_use_rs       = ($urandom_range(0, 99) < 75);
        id_use_rt       = ($urandom_range(0, 99) < 60);
        id_reg_write    = ($urandom_range(0, 99) < 75);
        id_mem_read     = ($urandom_range(0, 99) < 30);
        ex_branch_taken = ($urandom_range(0, 99) < 10);
        mem_busy        = ($urandom_range(0, 99) < 15);
    endtask

    task automatic check_cycle();
        int  ma, mb;
        bit  hz, e_pc, e_ifw, e_fl, e_bub, e_frz;
        ma = id_valid ? source_of(id_use_rs, int'(id_rs)) : 0;
        mb = id_valid ? source_of(id_use_rt, int'(id_rt)) : 0;
`ifdef HAZARD_FWD_EN
        hz = ((ma == 1) || (mb == 1)) && flight[0].mr;
`else
        hz = (ma != 0) || (mb != 0);
`endif
        e_pc = 1; e_ifw = 1; e_fl = 0; e_bub = 0; e_frz = 0;
        if (!reset_n) begin
            e_pc = 1;
        end else if (mem_busy) begin
            e_frz = 1; e_pc = 0; e_ifw = 0;
        end else if (ex_branch_taken) begin
            e_fl = 1; e_bub = 1;
        end else if (hz) begin
            e_pc = 0; e_ifw = 0; e_bub = 1;
        end
        check_val("pc_write", 32'(pc_write), int'(e_pc));
        check_val("ifid_write", 32'(ifid_write), int'(e_ifw));
        check_val("ifid_flush", 32'(ifid_flush), int'(e_fl));
        check_val("idex_bubble", 32'(idex_bubble), int'(e_bub));
        check_val("pipe_freeze", 32'(pipe_freeze), int'(e_frz));
        check_val("fwd_a_sel", 32'(fwd_a_sel), exp_a);
        check_val("fwd_b_sel", 32'(fwd_b_sel), exp_b);
        check_val("stall_cycles", 32'(stall_cycles), exp_cnt);
        if (reset_n) begin
            if (mem_busy || (hz && !ex_branch_taken))
                exp_cnt = (exp_cnt == 65535) ? 65535 : exp_cnt + 1;
            if (!mem_busy) begin
                flight[2] = flight[1];
                flight[1] = flight[0];
                if (e_bub) begin
                    flight[0] = '{0, 0, 0, 0};
                    exp_a = 0;
                    exp_b = 0;
                end else begin
                    flight[0] = '{id_valid, int'(id_rd), id_reg_write, id_mem_read};
`ifdef HAZARD_FWD_EN
                    exp_a = ma;
                    exp_b = mb;
`else
                    exp_a = 0;
                    exp_b = 0;
`endif
                end
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        randomize_inputs();
        clear_model();
        repeat (2) @(negedge clk);
        #1;
        check_cycle();
        @(negedge clk);
        reset_n = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (cyc == 1500) begin
                reset_n = 1'b0;
                clear_model();
            end else if (cyc == 1503) begin
                reset_n = 1'b1;
            end
            randomize_inputs();
            #1;
            check_cycle();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
